// File: rtl/data_sram_slave.sv
`default_nettype none
// ============================================================================
// data_sram_slave : single-port 32-bit word SRAM slave with access counters
// Revision 1.0 - initial release
// ============================================================================
module data_sram_slave #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic                  in_range;
  logic                  is_wr;
  logic                  is_rd;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_addr_lsb;

  assign in_range        = (data_sram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign idx             = data_sram_addr[ADDR_WIDTH+1:2];
  assign is_wr           = data_sram_en && (data_sram_wen != 4'b0000);
  assign is_rd           = data_sram_en && (data_sram_wen == 4'b0000);
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  // RAM contents are deliberately left out of the reset branch; writes are
  // still suppressed while reset is held.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sram_rdata <= 32'h0;
      rd_cnt          <= 32'h0;
      wr_cnt          <= 32'h0;
      addr_err        <= 1'b0;
    end else begin
      if (data_sram_en) begin
        // Read-first: a write cycle returns the word as it was before the write.
        data_sram_rdata <= in_range ? mem[idx] : 32'h0;
        if (!in_range) addr_err <= 1'b1;
      end
      if (is_wr && in_range) begin
        for (int b = 0; b < 4; b++) begin
          if (data_sram_wen[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
      if (is_rd) rd_cnt <= rd_cnt + 32'd1;
      if (is_wr) wr_cnt <= wr_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_slave.sv
`default_nettype none
// ============================================================================
// tb_data_sram_slave : directed self-checking bench for data_sram_slave
// Revision 1.0 - initial release
// ============================================================================
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .addr_err        (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one access for one clock, then sample just after the edge.
  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wen = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Access attempted during reset must not be counted
    en = 1'b1; wen = 4'hF; addr = 32'h10; wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata",  rdata,  32'h0);
    check("rst_rd_cnt", rd_cnt, 32'h0);
    check("rst_wr_cnt", wr_cnt, 32'h0);
    check("rst_err",    32'(addr_err), 32'h0);
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
    resetn = 1'b1;

    // Write then read
    access(4'hF, 32'h10, 32'hDEAD_BEEF);
    access(4'h0, 32'h10, 32'h0);
    check("wr_rd_data", rdata,  32'hDEAD_BEEF);
    check("wr_rd_wcnt", wr_cnt, 32'd1);
    check("wr_rd_rcnt", rd_cnt, 32'd1);

    // Byte merge (write cycle returns old word)
    access(4'hF, 32'h20, 32'h1122_3344);
    access(4'b0101, 32'h20, 32'hAABB_CCDD);
    check("merge_prewrite", rdata, 32'h1122_3344);
    access(4'h0, 32'h20, 32'h0);
    check("merge_data", rdata, 32'h11BB_33DD);

    // Read-first then new data
    access(4'hF, 32'h30, 32'h1);
    access(4'hF, 32'h30, 32'h2);
    check("rf_old", rdata, 32'h1);
    access(4'h0, 32'h30, 32'h0);
    check("rf_new", rdata, 32'h2);
    check("rf_wcnt", wr_cnt, 32'd5);
    check("rf_rcnt", rd_cnt, 32'd3);

    // Out of range
    access(4'hF, 32'h0, 32'hCAFE_F00D);
    check("oor_err_pre", 32'(addr_err), 32'h0);
    access(4'h0, 32'h0000_1000, 32'h0);
    check("oor_rd_data", rdata, 32'h0);
    check("oor_rd_err",  32'(addr_err), 32'h1);
    access(4'hF, 32'h0000_1000, 32'hFFFF_FFFF);
    access(4'h0, 32'h0, 32'h0);
    check("oor_wr_word0", rdata, 32'hCAFE_F00D);
    idle(100);
    check("oor_err_sticky", 32'(addr_err), 32'h1);
    check("oor_hold", rdata, 32'hCAFE_F00D);
    check("oor_rcnt", rd_cnt, 32'd5);
    check("oor_wcnt", wr_cnt, 32'd7);

    // Hold and asynchronous reset
    access(4'hF, 32'h44, 32'h5A5A_5A5A);
    access(4'h0, 32'h44, 32'h0);
    check("hold_rd", rdata, 32'h5A5A_5A5A);
    idle(10);
    check("hold_10", rdata, 32'h5A5A_5A5A);
    @(negedge clk);
    #2;
    en = 1'b1; wen = 4'hF; addr = 32'h44; wdata = 32'h0;
    resetn = 1'b0;
    #1;
    check("arst_rdata", rdata, 32'h0);
    check("arst_rcnt",  rd_cnt, 32'h0);
    check("arst_wcnt",  wr_cnt, 32'h0);
    check("arst_err",   32'(addr_err), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("arst_wcnt_hold", wr_cnt, 32'h0);
    @(negedge clk);
    en = 1'b0; wen = 4'h0;
    resetn = 1'b1;
    access(4'h0, 32'h44, 32'h0);
    check("arst_ram_kept", rdata, 32'h5A5A_5A5A);
    check("arst_rcnt1", rd_cnt, 32'd1);

    // Counter wrap
    @(negedge clk);
    en = 1'b0;
    force dut.rd_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.rd_cnt;
    access(4'h0, 32'h10, 32'h0);
    check("wrap_rcnt", rd_cnt, 32'h0);
    check("wrap_data", rdata, 32'hDEAD_BEEF);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
